// File: rtl/ps2_scancode_decoder_pkg.sv
// Shared PS/2 Set 2 prefix/housekeeping codes, key event type and decoder state encoding.
// Constants and types only: no latency, no flow control.
package ps2_scancode_decoder_pkg;

    localparam logic [7:0] PS2_PFX_EXT   = 8'hE0;
    localparam logic [7:0] PS2_PFX_BRK   = 8'hF0;
    localparam logic [7:0] PS2_PFX_PAUSE = 8'hE1;

    localparam logic [7:0] PS2_HK_BAT_OK = 8'hAA;
    localparam logic [7:0] PS2_HK_ACK    = 8'hFA;
    localparam logic [7:0] PS2_HK_RESEND = 8'hFE;
    localparam logic [7:0] PS2_HK_ECHO   = 8'hEE;
    localparam logic [7:0] PS2_HK_ERR0   = 8'h00;
    localparam logic [7:0] PS2_HK_ERR1   = 8'hFF;

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ps2_key_event_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXT,
        ST_BRK,
        ST_EXT_BRK,
        ST_SKIP
    } ps2_state_e;

    function automatic logic is_housekeeping(input logic [7:0] b);
        return (b == PS2_HK_BAT_OK) || (b == PS2_HK_ACK)  || (b == PS2_HK_RESEND) ||
               (b == PS2_HK_ECHO)   || (b == PS2_HK_ERR0) || (b == PS2_HK_ERR1);
    endfunction

endpackage

// File: rtl/ps2_held_keys.sv
// Held-key bitmap indexed by {ext, code}; query is combinational on the registered map.
// Set/clear take effect the cycle after they are asserted; no backpressure.
module ps2_held_keys (
    input  logic       clk,
    input  logic       rst,
    input  logic       set,
    input  logic       clr,
    input  logic [8:0] idx,
    output logic       held
);

    logic [511:0] map_q;

    assign held = map_q[idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            map_q <= '0;
        end else if (set) begin
            map_q[idx] <= 1'b1;
        end else if (clr) begin
            map_q[idx] <= 1'b0;
        end
    end

endmodule

// File: rtl/ps2_scancode_decoder.sv
// PS/2 Set 2 byte stream to key events; PS2_TYPEMATIC_FILTER_EN adds repeat suppression.
// Events and errors are registered 1 cycle after the strobe; no backpressure, every byte consumed.
module ps2_scancode_decoder
    import ps2_scancode_decoder_pkg::*;
#(
    parameter int TIMEOUT_CYCLES   = 100_000,
    parameter int PAUSE_SKIP_BYTES = 7
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ps2_key_data_i,
    input  logic       ps2_key_data_en_i,
    output logic [7:0] key_code_o,
    output logic       key_ext_o,
    output logic       key_break_o,
    output logic       key_valid_o,
    output logic       seq_err_o
);

    localparam int TMR_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int SKIP_W = $clog2(PAUSE_SKIP_BYTES + 1) > 0 ? $clog2(PAUSE_SKIP_BYTES + 1) : 1;
    localparam logic [TMR_W-1:0]  TMR_MAX   = TMR_W'(TIMEOUT_CYCLES);
    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PAUSE_SKIP_BYTES);

    ps2_state_e          state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [SKIP_W-1:0]   skip_q, skip_d;
    ps2_key_event_t      ev_q, ev_d;
    logic                valid_q, valid_d;
    logic                err_q, err_d;
    logic                cur_ext, cur_brk;
    logic                complete, emit;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic hk_set, hk_clr, hk_held;

    ps2_held_keys u_held_keys (
        .clk  (clk_i),
        .rst  (rst_i),
        .set  (hk_set),
        .clr  (hk_clr),
        .idx  ({cur_ext, ps2_key_data_i}),
        .held (hk_held)
    );
`endif

    assign cur_ext = (state_q == ST_EXT) || (state_q == ST_EXT_BRK);
    assign cur_brk = (state_q == ST_BRK) || (state_q == ST_EXT_BRK);

    always_comb begin
        state_d  = state_q;
        skip_d   = skip_q;
        err_d    = 1'b0;
        complete = 1'b0;
        if (ps2_key_data_en_i) begin
            if (state_q == ST_SKIP) begin
                // Pause tail is swallowed whole, even bytes that look like prefixes.
                if (skip_q <= SKIP_W'(1)) begin
                    skip_d  = '0;
                    state_d = ST_IDLE;
                end else begin
                    skip_d = skip_q - SKIP_W'(1);
                end
            end else if (ps2_key_data_i == PS2_PFX_PAUSE) begin
                err_d   = (state_q != ST_IDLE);
                state_d = ST_SKIP;
                skip_d  = SKIP_LOAD;
            end else if (ps2_key_data_i == PS2_PFX_EXT) begin
                err_d   = (state_q != ST_IDLE);
                state_d = ST_EXT;
            end else if (ps2_key_data_i == PS2_PFX_BRK) begin
                if (state_q == ST_IDLE) begin
                    state_d = ST_BRK;
                end else if (state_q == ST_EXT) begin
                    state_d = ST_EXT_BRK;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_BRK;
                end
            end else if (is_housekeeping(ps2_key_data_i)) begin
                err_d   = (state_q != ST_IDLE);
                state_d = ST_IDLE;
            end else begin
                complete = 1'b1;
                state_d  = ST_IDLE;
            end
        end else if ((state_q != ST_IDLE) && (timer_q == TMR_MAX)) begin
            err_d   = 1'b1;
            state_d = ST_IDLE;
            skip_d  = '0;
        end
    end

    always_comb begin
        emit = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
        hk_set = 1'b0;
        hk_clr = 1'b0;
        if (complete) begin
            if (cur_brk) begin
                hk_clr = 1'b1;
                emit   = 1'b1;
            end else if (!hk_held) begin
                hk_set = 1'b1;
                emit   = 1'b1;
            end
        end
`else
        emit = complete;
`endif
        valid_d = emit;
        ev_d    = ev_q;
        if (emit) begin
            ev_d.code = ps2_key_data_i;
            ev_d.ext  = cur_ext;
            ev_d.brk  = cur_brk;
        end
    end

    // Timer only runs while a sequence is open; any byte restarts the wait.
    always_comb begin
        timer_d = timer_q;
        if (ps2_key_data_en_i || (state_q == ST_IDLE)) begin
            timer_d = '0;
        end else if (timer_q != TMR_MAX) begin
            timer_d = timer_q + TMR_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            timer_q <= '0;
            skip_q  <= '0;
            ev_q    <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            skip_q  <= skip_d;
            ev_q    <= ev_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign key_code_o  = ev_q.code;
    assign key_ext_o   = ev_q.ext;
    assign key_break_o = ev_q.brk;
    assign key_valid_o = valid_q;
    assign seq_err_o   = err_q;

endmodule

// File: tb/tb_ps2_scancode_decoder.sv
// Directed stimulus for the PS/2 decoder; expected events/errors queued and checked by a monitor.
module tb_ps2_scancode_decoder;

    localparam int T = 40;

    typedef struct {
        bit         err;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        int         cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] data = 8'h00;
    logic       en = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_break, key_valid, seq_err;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sbq[$];

    ps2_scancode_decoder #(
        .TIMEOUT_CYCLES   (T),
        .PAUSE_SKIP_BYTES (7)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .ps2_key_data_i    (data),
        .ps2_key_data_en_i (en),
        .key_code_o        (key_code),
        .key_ext_o         (key_ext),
        .key_break_o       (key_break),
        .key_valid_o       (key_valid),
        .seq_err_o         (seq_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [7:0] b);
        data = b;
        en   = 1'b1;
        @(posedge clk);
        #1;
        en   = 1'b0;
    endtask

    task automatic push_ev(input logic [7:0] c, input logic x, input logic b, input int at);
        exp_t e;
        e.err = 1'b0; e.code = c; e.ext = x; e.brk = b; e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic push_err(input int at);
        exp_t e;
        e.err = 1'b1; e.code = 8'h00; e.ext = 1'b0; e.brk = 1'b0; e.cyc = at;
        sbq.push_back(e);
    endtask

    task automatic drive_ev(input logic [7:0] b, input logic x, input logic k);
        push_ev(b, x, k, cyc + 1);
        drive(b);
    endtask

    task automatic drive_err(input logic [7:0] b);
        push_err(cyc + 1);
        drive(b);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!rst && (key_valid || seq_err)) begin
            n_cmp++;
            if (sbq.size() == 0) begin
                n_bad++;
                $display("FAIL unexpected_output: valid=%0b err=%0b code=%h ext=%0b brk=%0b cyc=%0d, expected nothing",
                         key_valid, seq_err, key_code, key_ext, key_break, cyc);
            end else begin
                e = sbq.pop_front();
                if (e.err) begin
                    if (!(seq_err === 1'b1 && key_valid === 1'b0 && cyc == e.cyc)) begin
                        n_bad++;
                        $display("FAIL seq_err: got err=%0b valid=%0b cyc=%0d, expected err=1 valid=0 cyc=%0d",
                                 seq_err, key_valid, cyc, e.cyc);
                    end
                end else begin
                    if (!(key_valid === 1'b1 && seq_err === 1'b0 && key_code === e.code &&
                          key_ext === e.ext && key_break === e.brk && cyc == e.cyc)) begin
                        n_bad++;
                        $display("FAIL key_event: got valid=%0b err=%0b code=%h ext=%0b brk=%0b cyc=%0d, expected code=%h ext=%0b brk=%0b cyc=%0d",
                                 key_valid, seq_err, key_code, key_ext, key_break, cyc,
                                 e.code, e.ext, e.brk, e.cyc);
                    end
                end
            end
        end
    end

    initial begin
        int c;
        rst = 1'b1;
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_code",  key_code, 8'h00);
        chk("reset_ext",   {7'd0, key_ext}, 8'h00);
        chk("reset_break", {7'd0, key_break}, 8'h00);
        chk("reset_valid", {7'd0, key_valid}, 8'h00);
        chk("reset_err",   {7'd0, seq_err}, 8'h00);
        idle(1);

        // Housekeeping byte in IDLE: silent.
        drive(8'hAA);
        idle(2);

        // Plain make, then data outputs must hold.
        drive_ev(8'h1C, 1'b0, 1'b0);
        idle(4);
        chk("hold_code", key_code, 8'h1C);

        // Extended break on consecutive strobes.
        drive(8'hE0);
        drive(8'hF0);
        drive_ev(8'h75, 1'b1, 1'b1);
        idle(2);

        // Pause sequence swallowed entirely.
        drive(8'hE1); drive(8'h14); drive(8'h77); drive(8'hE1);
        drive(8'hF0); drive(8'h14); drive(8'hF0); drive(8'h77);
        drive_ev(8'h2C, 1'b0, 1'b0);
        idle(2);

        // Timeout on an open E0.
        c = cyc;
        push_err(c + 2 + T);
        drive(8'hE0);
        idle(T + 5);
        drive_ev(8'h74, 1'b0, 1'b0);
        idle(2);

        // Strobe on the expiry cycle: byte wins, no error.
        drive(8'hE0);
        idle(T);
        drive_ev(8'h74, 1'b1, 1'b0);
        idle(T + 5);

        // Illegal prefix order.
        drive(8'hF0);
        drive_err(8'hE0);
        drive_ev(8'h6B, 1'b1, 1'b0);
        idle(2);

        // Housekeeping inside a sequence.
        drive(8'hE0);
        drive_err(8'hFA);
        drive_ev(8'h2B, 1'b0, 1'b0);
        idle(2);

        // E1 interrupting a break prefix.
        drive(8'hF0);
        drive_err(8'hE1);
        drive(8'h14); drive(8'h77); drive(8'hE1); drive(8'hF0);
        drive(8'h14); drive(8'hF0); drive(8'h77);
        drive_ev(8'h3C, 1'b0, 1'b0);
        idle(2);

        // Typematic repeats.
`ifdef PS2_TYPEMATIC_FILTER_EN
        drive_ev(8'h1D, 1'b0, 1'b0);
        drive(8'h1D);
        drive(8'h1D);
        drive(8'hF0);
        drive_ev(8'h1D, 1'b0, 1'b1);
        drive_ev(8'h1D, 1'b0, 1'b0);
`else
        drive_ev(8'h1D, 1'b0, 1'b0);
        drive_ev(8'h1D, 1'b0, 1'b0);
        drive_ev(8'h1D, 1'b0, 1'b0);
        drive(8'hF0);
        drive_ev(8'h1D, 1'b0, 1'b1);
        drive_ev(8'h1D, 1'b0, 1'b0);
`endif
        idle(3);

        // Reset mid-sequence: silent discard, outputs cleared.
        drive(8'hE0);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        @(negedge clk);
        chk("midreset_code", key_code, 8'h00);
        chk("midreset_err",  {7'd0, seq_err}, 8'h00);
        idle(1);
        drive_ev(8'h4D, 1'b0, 1'b0);

        idle(T + 10);
        n_cmp++;
        if (sbq.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: %0d expected outputs never seen, expected 0", sbq.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/ps2_scancode_decoder.md
Name: ps2_scancode_decoder

Overview:
Converts the raw PS/2 byte stream (Set 2 scan codes) from PS2_Controller into single-cycle key events (code, extended flag, make/break). Sits between PS2_Controller and user_input in the CLOCK_50 (PS/2) domain.
Strips the E0/F0/E1 prefixes and discards keyboard housekeeping bytes. Abandons stale partial sequences via an inter-byte timeout.

Parameters:
TIMEOUT_CYCLES, 100_000, clk_i cycles (2 ms at 50 MHz) a partial sequence may wait for its next byte before being dropped.
PAUSE_SKIP_BYTES, 7, bytes discarded after an E1 prefix (remainder of the Pause sequence).

Ports:
clk_i  in  1  PS/2-domain clock (CLOCK_50)
rst_i  in  1  synchronous, active-high reset
ps2_key_data_i  in  8  byte from PS2_Controller
ps2_key_data_en_i  in  1  one-cycle strobe, byte valid
key_code_o  out  8  scan code without prefixes
key_ext_o  out  1  1 = code was preceded by E0
key_break_o  out  1  1 = release (F0 seen), 0 = press
key_valid_o  out  1  one-cycle strobe; the three fields above are valid this cycle
seq_err_o  out  1  one-cycle strobe: illegal prefix order or timeout dropped a sequence

Behaviour:
- Interface: one clock, clk_i; reset rst_i is synchronous and active-high.
- Reset: all outputs 0, FSM in IDLE, timer 0, skip counter 0, held bitmap cleared. Reset mid-sequence discards the partial sequence silently (no seq_err_o).
- FSM states: IDLE, EXT, BRK, EXT_BRK, SKIP. The state advances only on cycles with ps2_key_data_en_i=1, except timeout.
- Prefix transitions:
  - IDLE + E0 -> EXT; IDLE + F0 -> BRK; EXT + F0 -> EXT_BRK.
  - Any other E0/F0 arrival is illegal: pulse seq_err_o, then treat the byte as if received in IDLE (E0 -> EXT, F0 -> BRK).
- E1 in any state:
  - From non-IDLE: pulse seq_err_o.
  - Enter SKIP with the counter loaded to PAUSE_SKIP_BYTES. Each strobe decrements it; return to IDLE after the strobe that brings it to 0.
  - No events are emitted for Pause.
- Housekeeping bytes: in IDLE, bytes AA, FA, FE, EE, 00, FF are dropped with no event. In any non-IDLE state except SKIP they are illegal: pulse seq_err_o, return to IDLE.
- Completing byte (any other value in IDLE/EXT/BRK/EXT_BRK):
  - Register key_code_o = byte, key_ext_o = (state in EXT/EXT_BRK), key_break_o = (state in BRK/EXT_BRK), key_valid_o = 1.
  - Outputs appear exactly 1 cycle after the strobe. Return to IDLE.
- key_valid_o and seq_err_o are high for one cycle only. The data outputs hold their last value between events.
- Timeout:
  - The timer clears on every strobe and counts while the state is not IDLE; it saturates at TIMEOUT_CYCLES.
  - On reaching TIMEOUT_CYCLES: pulse seq_err_o, go to IDLE. This applies to SKIP as well.
  - If a strobe coincides with the expiry cycle, the byte wins: it is processed in the current state and no timeout error is raised.
- Timer width is $clog2(TIMEOUT_CYCLES+1).
- Back-to-back strobes on consecutive cycles are supported; there is no backpressure and every byte is consumed.

Optional Feature:
Macro PS2_TYPEMATIC_FILTER_EN.
- Defined:
  - A 2x256-bit held-key bitmap, indexed by {ext, code}, suppresses typematic repeats.
  - A make on an already-held key emits nothing. A make on a non-held key sets its bit and emits.
  - A break clears the bit and always emits.
  - Reset clears the bitmap.
- Undefined: every make is emitted, including typematic repeats; no bitmap is instantiated.

Decomposition:
- Shared (defs.vh): localparams PS2_PFX_EXT=8'hE0, PS2_PFX_BRK=8'hF0, PS2_PFX_PAUSE=8'hE1 and the housekeeping codes.
- Shared (defs.vh): typedef ps2_key_event_t {code[7:0], ext, brk}, for user_input to reuse.
- Sub-module ps2_held_keys holds the bitmap. It has a set/clear/query interface, is one-cycle combinational query on the registered map, and is instantiated only under PS2_TYPEMATIC_FILTER_EN.

Test Plan:
- Byte 1C -> one cycle later key_valid_o=1, key_code_o=1C, ext=0, break=0.
- Bytes E0,F0,75 on consecutive cycles -> single event code=75, ext=1, break=1 one cycle after the 75 strobe; no event on the prefixes.
- E1,14,77,E1,F0,14,F0,77 -> no key_valid_o, no seq_err_o, FSM back in IDLE; a following 1C decodes normally.
- E0, then idle for TIMEOUT_CYCLES -> seq_err_o pulse and IDLE. Next byte 74 -> code=74, ext=0. Also: strobe on the expiry cycle -> no error.
- F0,E0,6B -> seq_err_o at E0, then event code=6B, ext=1, break=0. Byte AA after reset -> no event, no error.
- With PS2_TYPEMATIC_FILTER_EN: 1D,1D,1D,F0,1D,1D -> events make, break, make (3 total). Without the macro: 5 events.
